// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: one word access at a time, word-addressed storage.
// Latency: response pulse LATENCY cycles after acceptance (LATENCY = 1..15); next request accepted the cycle after.
// Backpressure: req_ready is low while a request is outstanding; the response has no back-pressure.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready handshake; req_we, req_addr (byte address), req_wdata, req_be
//   rsp_valid (one-cycle pulse), rsp_rdata, rsp_err; busy = request outstanding (core stall)
// Build option: define DMEM_BE_EN to honour req_be on stores; otherwise stores write all four lanes.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] idx;
  logic              req_err;
  logic [3:0]        wr_be;

  assign accept  = req_valid & req_ready;
  assign idx     = req_addr[ADDR_W+1:2];
  // Misaligned or beyond the storage depth; either rejects the request.
  assign req_err = (|req_addr[1:0]) | (|req_addr[31:ADDR_W+2]);

`ifdef DMEM_BE_EN
  assign wr_be = req_be;
`else
  logic unused_be;
  assign unused_be = ^req_be;
  assign wr_be     = 4'hF;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = req_err;
          // Load data is snapshotted now, so the response is independent of later writes.
          rdata_d = (!req_we && !req_err) ? mem_q[idx] : 32'h0;
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage clears on reset; stores commit on the acceptance edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        r1_valid, r1_we;
  logic [31:0] r1_addr, r1_wdata;
  logic [3:0]  r1_be;
  logic        r1_ready, r1_rsp_valid, r1_rsp_err, r1_busy;
  logic [31:0] r1_rsp_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(r1_valid), .req_ready(r1_ready), .req_we(r1_we),
    .req_addr(r1_addr), .req_wdata(r1_wdata), .req_be(r1_be),
    .rsp_valid(r1_rsp_valid), .rsp_rdata(r1_rsp_rdata), .rsp_err(r1_rsp_err), .busy(r1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // Issues one request on the LATENCY=2 instance and follows it to its response.
  // lat = edges after the acceptance edge until rsp_valid is seen (-1 on timeout);
  // hs_ok = ready/busy low/high while outstanding and everything idle the cycle after the pulse.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat, output logic hs_ok);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    lat = 0;
    hs_ok = 1'b1;
    while (!rsp_valid && lat < 20) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (lat >= 20) lat = -1;
    rdata = rsp_rdata;
    err   = rsp_err;
    if (req_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        req_ready !== 1'b1 || busy !== 1'b0) hs_ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat; logic ok;
    logic [31:0] addrs [3];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'hFFC;
    tests_run++;
    if ({req_ready, busy, rsp_valid, rsp_err} !== 4'b1000 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready/busy/valid/err=%b rdata=%h, required 1000 rdata=0",
               {req_ready, busy, rsp_valid, rsp_err}, rsp_rdata);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL idle_after_reset: ready/busy/valid=%b, required 100", {req_ready, busy, rsp_valid});
    end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, addrs[i], 32'h0, 4'h0, rd, er, lat, ok);
      tests_run++;
      if (rd !== 32'h0 || er !== 1'b0 || lat !== 1 || ok !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_read_%h: rdata=%h err=%b lat=%0d hs=%b, required 0 0 1 1",
                 addrs[i], rd, er, lat, ok);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; logic ok;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, ok);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 1 || ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL store_rsp: rdata=%h err=%b lat=%0d hs=%b, required 0 0 1 1", rd, er, lat, ok);
    end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ok);
    tests_run++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 1 || ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_rsp: rdata=%h err=%b lat=%0d hs=%b, required deadbeef 0 1 1", rd, er, lat, ok);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat; logic ok;
    logic [31:0] exp;
`ifdef DMEM_BE_EN
    exp = 32'hDE22BE44;
`else
    exp = 32'h11223344;
`endif
    do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat, ok);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ok);
    tests_run++;
    if (rd !== exp || er !== 1'b0 || ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL byte_enable: rdata=%h err=%b hs=%b, required %h 0 1", rd, er, ok, exp);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; logic ok;
    do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat, ok);
    do_req(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat, ok);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 1 || ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_load: rdata=%h err=%b lat=%0d hs=%b, required 0 1 1 1", rd, er, lat, ok);
    end
    do_req(1'b1, 32'h1000, 32'h55555555, 4'hF, rd, er, lat, ok);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 1 || ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL out_of_range_store: rdata=%h err=%b lat=%0d hs=%b, required 0 1 1 1", rd, er, lat, ok);
    end
    do_req(1'b1, 32'h2, 32'h77777777, 4'hF, rd, er, lat, ok);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, ok);
    tests_run++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL word0_after_errors: rdata=%h err=%b, required cafef00d 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int na, np;
    logic [8:0] busy_s;
    na = 0; np = 0; busy_s = '0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0;
    for (int c = 0; c < 9; c++) begin
      if (req_valid && req_ready && na < 3) begin
        acc[na] = c; na++;
      end
      @(posedge clk); #1;
      busy_s[c] = busy;
      if (rsp_valid) np++;
      if (na == 3) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    tests_run++;
    if (acc[0] !== 0 || acc[1] !== 3 || acc[2] !== 6) begin
      tests_failed++;
      $display("FAIL b2b_accept: cycles %0d %0d %0d, required 0 3 6", acc[0], acc[1], acc[2]);
    end
    tests_run++;
    if (busy_s !== 9'b011011011) begin
      tests_failed++;
      $display("FAIL b2b_busy: pattern(c8..c0)=%b, required 011011011", busy_s);
    end
    tests_run++;
    if (np !== 3) begin
      tests_failed++;
      $display("FAIL b2b_pulses: count=%0d, required 3", np);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat; logic ok;
    logic seen;
    seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_state: busy=%b ready=%b, required 1 0", busy, req_ready);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, busy, rsp_valid, rsp_err} !== 4'b1000 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_wait: ready/busy/valid/err=%b rdata=%h, required 1000 rdata=0",
               {req_ready, busy, rsp_valid, rsp_err}, rsp_rdata);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL discarded_rsp: rsp_valid seen=%b, required 0", seen);
    end
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, ok);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL mem_cleared_20: rdata=%h err=%b, required 0 0", rd, er);
    end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ok);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL mem_cleared_10: rdata=%h, required 0", rd);
    end
  endtask

  task automatic test_latency1();
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 32'h8; r1_wdata = 32'hA5A5A5A5; r1_be = 4'hF;
    tests_run++;
    if (r1_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL l1_ready: ready=%b, required 1", r1_ready);
    end
    @(posedge clk); #1;
    r1_valid = 1'b0; r1_we = 1'b0;
    tests_run++;
    if (r1_rsp_valid !== 1'b1 || r1_rsp_err !== 1'b0 || r1_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL l1_store_rsp: valid=%b err=%b busy=%b, required 1 0 1", r1_rsp_valid, r1_rsp_err, r1_busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (r1_rsp_valid !== 1'b0 || r1_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL l1_idle: valid=%b ready=%b, required 0 1", r1_rsp_valid, r1_ready);
    end
    r1_valid = 1'b1; r1_addr = 32'h8;
    @(posedge clk); #1;
    r1_valid = 1'b0;
    tests_run++;
    if (r1_rsp_valid !== 1'b1 || r1_rsp_rdata !== 32'hA5A5A5A5) begin
      tests_failed++;
      $display("FAIL l1_load_rsp: valid=%b rdata=%h, required 1 a5a5a5a5", r1_rsp_valid, r1_rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0; r1_be = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_latency1();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
